// File: rtl/fifo_usage_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_usage_tracker_if
// Description : Handshake/status bundle for fifo_usage_tracker.
//               master = producer/consumer side, slave = the FIFO itself.
//               Signals: wr_en, wr_data, rd_en (requests);
//                        rd_data, rd_valid (read response);
//                        full, empty, count, mem_used, overflow, underflow
//                        (occupancy status).
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_usage_tracker_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic [7:0]       mem_used;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, count, mem_used, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, count, mem_used, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_usage_tracker.sv
`default_nettype none
// ============================================================================
// Module      : fifo_usage_tracker
// Description : Synchronous FIFO that also reports its fill level as an
//               integer percentage floor(count*100/DEPTH) on mem_used.
// Ports       : clk   - sole clock, rising edge
//               reset - asynchronous, active-high
//               bus   - fifo_usage_tracker_if.slave (requests in, read data
//                       and registered occupancy/status flags out)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_usage_tracker #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  wire                   clk,
  input  wire                   reset,
  fifo_usage_tracker_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // count (AW+1 bits) times 100 (7 bits) fits in AW+8 bits.
  localparam int PW = AW + 8;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_full;
  logic             r_empty;
  logic [7:0]       r_mem_used;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [CW-1:0]    w_count_next;
  logic [PW-1:0]    w_product;
  logic [7:0]       w_mem_used;

  // Acceptance uses the registered flags, so a read at empty is rejected
  // even when a write arrives in the same cycle (no bypass path).
  assign w_wr_acc = bus.wr_en & ~r_full;
  assign w_rd_acc = bus.rd_en & ~r_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Percentage derived from the next count so it moves on the same edge as
  // count; DEPTH is a power of two so the divide is a shift. Result <= 100,
  // so the MSB is always 0.
  assign w_product  = PW'(w_count_next) * PW'(7'd100);
  assign w_mem_used = 8'(w_product >> AW);

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wp] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_mem_used  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rp];
        r_rp      <= r_rp + AW'(1);
      end
      r_count    <= w_count_next;
      r_full     <= (w_count_next == CW'(DEPTH));
      r_empty    <= (w_count_next == '0);
      r_mem_used <= w_mem_used;
      // Sticky until reset.
      if (bus.wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
      if (bus.rd_en && r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.full      = r_full;
  assign bus.empty     = r_empty;
  assign bus.count     = r_count;
  assign bus.mem_used  = r_mem_used;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule
`default_nettype wire
